// File: rtl/hwpe_stream_traffic_ctrl_if.sv
// Control/status bundle between the traffic scheduler and the test harness.
// Latency: n/a (wires only).
// Backpressure: none; all signals are level or single-cycle pulses.
interface hwpe_stream_traffic_ctrl_if #(
  parameter int unsigned NB_RECV = 2
);
  logic                     start_i;
  logic                     clear_i;
  logic [NB_RECV-1:0]       mask_i;
  logic                     force_ready_mode_i;
  logic [NB_RECV-1:0]       eot_i;
  logic [NB_RECV-1:0]       enable_o;
  logic [NB_RECV-1:0]       force_ready_o;
  logic [NB_RECV-1:0]       force_unready_o;
  logic [NB_RECV-1:0][31:0] rng_o;
  logic                     busy_o;
  logic                     done_o;
  logic                     timeout_o;
  logic [31:0]              cycle_cnt_o;

  // Scheduler side.
  modport master (
    input  start_i, clear_i, mask_i, force_ready_mode_i, eot_i,
    output enable_o, force_ready_o, force_unready_o, rng_o,
    output busy_o, done_o, timeout_o, cycle_cnt_o
  );

  // Test program / receiver side.
  modport slave (
    output start_i, clear_i, mask_i, force_ready_mode_i, eot_i,
    input  enable_o, force_ready_o, force_unready_o, rng_o,
    input  busy_o, done_o, timeout_o, cycle_cnt_o
  );
endinterface

// File: rtl/hwpe_stream_traffic_ctrl.sv
// Sequences stream receivers through a run: enables, stall bursts, per-receiver RNG, done/timeout.
// Latency: outputs follow start/mode inputs by one cycle; all outputs decode registered state.
// Backpressure: none; eot_i is polled each RUN cycle, start_i ignored outside IDLE.
module hwpe_stream_traffic_ctrl #(
  parameter int unsigned NB_RECV        = 2,
  parameter logic [31:0] SEED           = 32'h1,
  parameter int unsigned STALL_PERIOD   = 64,
  parameter int unsigned STALL_LEN      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input logic                       clk_i,
  input logic                       rst_ni,
  hwpe_stream_traffic_ctrl_if.master ctrl
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TIMEOUT} state_e;

  // Galois taps for x^32+x^22+x^2+x+1, right-shifting form.
  localparam logic [31:0] TAPS = 32'h8020_0003;

  state_e                   state_q, state_d;
  logic [NB_RECV-1:0]       mask_q;
  logic [NB_RECV-1:0]       fr_q;
  logic [31:0]              cnt_q;
  logic [31:0]              stall_q;
  logic [NB_RECV-1:0][31:0] lfsr_q;
  logic                     all_eot;

  function automatic logic [31:0] seed_of(input int unsigned idx);
    logic [31:0] s;
    s = SEED + 32'(idx);
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

  // Next-state: completion beats timeout when both hit on the same cycle.
  always_comb begin
    state_d = state_q;
    all_eot = &(ctrl.eot_i | ~mask_q);
    case (state_q)
      IDLE:    if (ctrl.start_i) state_d = RUN;
      RUN: begin
        if (all_eot)
          state_d = DONE;
        else if (TIMEOUT_CYCLES != 0 && cnt_q >= 32'(TIMEOUT_CYCLES - 1))
          state_d = TIMEOUT;
      end
      DONE:    if (ctrl.clear_i) state_d = IDLE;
      TIMEOUT: if (ctrl.clear_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, run bookkeeping and per-receiver LFSRs (LFSRs only reseeded by reset).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      mask_q  <= '0;
      fr_q    <= '0;
      cnt_q   <= '0;
      stall_q <= '0;
      for (int i = 0; i < NB_RECV; i++) lfsr_q[i] <= seed_of(i);
    end else begin
      state_q <= state_d;
      if (state_d == RUN && ctrl.force_ready_mode_i)
        fr_q <= (state_q == IDLE) ? ctrl.mask_i : mask_q;
      else
        fr_q <= '0;
      case (state_q)
        IDLE: begin
          if (ctrl.start_i) begin
            mask_q  <= ctrl.mask_i;
            cnt_q   <= '0;
            stall_q <= '0;
          end
        end
        RUN: begin
          if (cnt_q != 32'hFFFF_FFFF) cnt_q <= cnt_q + 32'd1;
          if (STALL_PERIOD != 0)
            stall_q <= (stall_q == 32'(STALL_PERIOD - 1)) ? 32'd0 : stall_q + 32'd1;
          for (int i = 0; i < NB_RECV; i++)
            lfsr_q[i] <= {1'b0, lfsr_q[i][31:1]} ^ (lfsr_q[i][0] ? TAPS : 32'd0);
        end
        default: begin
          if (ctrl.clear_i) cnt_q <= '0;
        end
      endcase
    end
  end

  // Output decode; everything is forced quiet outside RUN.
  always_comb begin
    logic [9:0] v;
    ctrl.busy_o          = (state_q == RUN);
    ctrl.done_o          = (state_q == DONE);
    ctrl.timeout_o       = (state_q == TIMEOUT);
    ctrl.cycle_cnt_o     = cnt_q;
    ctrl.enable_o        = (state_q == RUN) ? mask_q : '0;
    ctrl.force_ready_o   = fr_q;
    ctrl.force_unready_o = '0;
    if (state_q == RUN && STALL_PERIOD != 0 && stall_q < 32'(STALL_LEN))
      ctrl.force_unready_o = mask_q;
    ctrl.rng_o = '0;
    for (int i = 0; i < NB_RECV; i++) begin
      v = lfsr_q[i][9:0];
      if (v >= 10'd1000) v = v - 10'd1000;
      if (state_q == RUN) ctrl.rng_o[i] = {22'd0, v};
    end
  end

endmodule

// File: tb/tb_hwpe_stream_traffic_ctrl.sv
// Scoreboard bench for hwpe_stream_traffic_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them, and RNG runs are recorded for a reset-replay check.
module tb_hwpe_stream_traffic_ctrl;
  localparam int NB = 2;
  localparam int S_EN = 0, S_FR = 1, S_FU = 2, S_BUSY = 3, S_DONE = 4,
                 S_TO = 5, S_CNT = 6, S_R0 = 7, S_R1 = 8;

  typedef struct {
    int unsigned cyc;
    int          sel;
    logic [31:0] exp;
    int          tid;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  hwpe_stream_traffic_ctrl_if #(.NB_RECV(NB)) bus();

  hwpe_stream_traffic_ctrl #(
    .NB_RECV(NB), .SEED(32'h1), .STALL_PERIOD(8), .STALL_LEN(2), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .ctrl(bus)
  );

  exp_t        q[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  int          tid = 0;
  logic [63:0] rec0[$];
  logic [63:0] rec1[$];
  bit          rec_on = 1'b0;
  int          rec_sel = 0;
  int          range_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] act(input int sel);
    case (sel)
      S_EN:    return 32'(bus.enable_o);
      S_FR:    return 32'(bus.force_ready_o);
      S_FU:    return 32'(bus.force_unready_o);
      S_BUSY:  return 32'(bus.busy_o);
      S_DONE:  return 32'(bus.done_o);
      S_TO:    return 32'(bus.timeout_o);
      S_CNT:   return bus.cycle_cnt_o;
      S_R0:    return bus.rng_o[0];
      S_R1:    return bus.rng_o[1];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string sname(input int sel);
    case (sel)
      S_EN:    return "enable";
      S_FR:    return "force_ready";
      S_FU:    return "force_unready";
      S_BUSY:  return "busy";
      S_DONE:  return "done";
      S_TO:    return "timeout";
      S_CNT:   return "cycle_cnt";
      S_R0:    return "rng0";
      S_R1:    return "rng1";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compare every expectation due this cycle, record RNG while busy.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL t%0d %s: check for cycle %0d missed (now %0d)", e.tid, sname(e.sel), e.cyc, cyc);
      end else if (act(e.sel) !== e.exp) begin
        errors++;
        $display("FAIL t%0d %s @cyc %0d: got %0d, expected %0d", e.tid, sname(e.sel), cyc, act(e.sel), e.exp);
      end
    end
    if (rec_on && bus.busy_o) begin
      if (bus.rng_o[0] > 32'd999 || bus.rng_o[1] > 32'd999) range_bad++;
      if (rec_sel == 0) rec0.push_back({bus.rng_o[1], bus.rng_o[0]});
      else              rec1.push_back({bus.rng_o[1], bus.rng_o[0]});
    end
  end

  task automatic ex(input int unsigned at, input int sel, input logic [31:0] v);
    exp_t e;
    int   idx;
    e.cyc = at; e.sel = sel; e.exp = v; e.tid = tid;
    idx = q.size();
    while (idx > 0 && q[idx-1].cyc > at) idx--;
    q.insert(idx, e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned t);
    while (cyc < t) step(1);
  endtask

  task automatic start_run(input logic [1:0] m);
    bus.mask_i = m; bus.start_i = 1'b1;
    step(1);
    bus.start_i = 1'b0; bus.mask_i = 2'b00;
  endtask

  task automatic clear_run();
    bus.clear_i = 1'b1;
    step(1);
    bus.clear_i = 1'b0;
  endtask

  task automatic rng_pass(input int p);
    rec_sel = p;
    rec_on  = 1'b1;
    for (int r = 0; r < 200; r++) begin
      if (r == 0) begin
        ex(cyc + 1, S_R0, 32'd1);
        ex(cyc + 1, S_R1, 32'd2);
      end
      start_run(2'b11);
      for (int w = 0; w < 60; w++) begin
        if (bus.timeout_o) break;
        step(1);
      end
      vectors++;
      if (!bus.timeout_o) begin
        errors++;
        $display("FAIL rng_pass%0d run %0d: timeout_o=%0b, required 1 within 60 cycles", p, r, bus.timeout_o);
      end
      clear_run();
    end
    rec_on = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned s;
    int          nd;
    bus.start_i = 1'b0; bus.clear_i = 1'b0; bus.mask_i = 2'b00;
    bus.force_ready_mode_i = 1'b0; bus.eot_i = 2'b00;
    #1 rst_ni = 1'b0;

    // Reset state.
    step(2);
    tid = 0;
    ex(cyc, S_EN, 0); ex(cyc, S_FR, 0); ex(cyc, S_FU, 0); ex(cyc, S_BUSY, 0);
    ex(cyc, S_DONE, 0); ex(cyc, S_TO, 0); ex(cyc, S_CNT, 0); ex(cyc, S_R0, 0);
    step(1); rst_ni = 1'b1; step(1);

    // Full run with stall bursts, RNG start values, done at cycle 20, clear (+ignored start).
    tid = 1; s = cyc + 1;
    ex(s - 1, S_EN, 0); ex(s - 1, S_BUSY, 0);
    for (int k = 0; k <= 20; k++) begin
      ex(s + k, S_EN, 3); ex(s + k, S_BUSY, 1); ex(s + k, S_DONE, 0);
      ex(s + k, S_CNT, 32'(k));
      ex(s + k, S_FU, ((k % 8) < 2) ? 32'd3 : 32'd0);
    end
    ex(s, S_R0, 1); ex(s, S_R1, 2); ex(s + 1, S_R0, 3); ex(s + 1, S_R1, 1);
    ex(s + 2, S_R0, 2); ex(s + 2, S_R1, 3); ex(s + 3, S_R0, 1); ex(s + 3, S_R1, 2);
    for (int k = 21; k <= 26; k++) begin
      ex(s + k, S_DONE, 1); ex(s + k, S_EN, 0); ex(s + k, S_FU, 0);
      ex(s + k, S_BUSY, 0); ex(s + k, S_CNT, 21); ex(s + k, S_R0, 0);
    end
    ex(s + 27, S_DONE, 0); ex(s + 27, S_BUSY, 0); ex(s + 27, S_CNT, 0); ex(s + 28, S_BUSY, 0);
    start_run(2'b11);
    wait_cyc(s + 10); bus.eot_i = 2'b01;
    wait_cyc(s + 20); bus.eot_i = 2'b11;
    wait_cyc(s + 26); bus.clear_i = 1'b1; bus.start_i = 1'b1; bus.mask_i = 2'b11;
    step(1); bus.clear_i = 1'b0; bus.start_i = 1'b0; bus.mask_i = 2'b00; bus.eot_i = 2'b00;
    step(2);

    // Unmasked receiver ignored.
    tid = 3; s = cyc + 1;
    for (int k = 0; k <= 5; k++) begin
      ex(s + k, S_EN, 1); ex(s + k, S_BUSY, 1); ex(s + k, S_DONE, 0);
    end
    ex(s, S_FU, 1);
    ex(s + 6, S_DONE, 1); ex(s + 6, S_EN, 0); ex(s + 6, S_CNT, 6);
    start_run(2'b01);
    wait_cyc(s + 5); bus.eot_i = 2'b01;
    wait_cyc(s + 7); clear_run(); bus.eot_i = 2'b00; step(1);

    // Empty mask completes after one RUN cycle.
    tid = 4; s = cyc + 1;
    ex(s, S_BUSY, 1); ex(s, S_EN, 0); ex(s + 1, S_DONE, 1); ex(s + 1, S_CNT, 1);
    start_run(2'b00);
    wait_cyc(s + 2); clear_run(); step(1);

    // Timeout after 50 RUN cycles, held until clear.
    tid = 5; s = cyc + 1;
    ex(s + 49, S_BUSY, 1); ex(s + 49, S_TO, 0); ex(s + 49, S_CNT, 49);
    ex(s + 50, S_TO, 1); ex(s + 50, S_DONE, 0); ex(s + 50, S_CNT, 50); ex(s + 50, S_EN, 0);
    ex(s + 53, S_TO, 1); ex(s + 53, S_CNT, 50); ex(s + 55, S_TO, 0); ex(s + 55, S_CNT, 0);
    start_run(2'b11);
    wait_cyc(s + 54); clear_run(); step(1);

    // Completion on the timeout cycle: done wins.
    tid = 6; s = cyc + 1;
    ex(s + 49, S_BUSY, 1); ex(s + 50, S_DONE, 1); ex(s + 50, S_TO, 0); ex(s + 50, S_CNT, 50);
    start_run(2'b11);
    wait_cyc(s + 49); bus.eot_i = 2'b11;
    wait_cyc(s + 51); clear_run(); bus.eot_i = 2'b00; step(1);

    // force_ready follows mode with one cycle latency; start in RUN ignored.
    tid = 7; s = cyc + 1;
    for (int k = 0; k <= 7; k++) begin
      ex(s + k, S_FR, (k >= 3 && k <= 5) ? 32'd2 : 32'd0);
      ex(s + k, S_EN, 2);
    end
    ex(s + 5, S_BUSY, 1); ex(s + 6, S_BUSY, 1); ex(s + 6, S_CNT, 6);
    ex(s + 9, S_DONE, 1); ex(s + 9, S_CNT, 9); ex(s + 9, S_FR, 0);
    start_run(2'b10);
    wait_cyc(s + 2); bus.force_ready_mode_i = 1'b1;
    wait_cyc(s + 4); bus.start_i = 1'b1; bus.mask_i = 2'b01;
    wait_cyc(s + 5); bus.start_i = 1'b0; bus.mask_i = 2'b00; bus.force_ready_mode_i = 1'b0;
    wait_cyc(s + 8); bus.eot_i = 2'b10;
    wait_cyc(s + 10); clear_run(); bus.eot_i = 2'b00; step(1);

    // Asynchronous reset mid-RUN.
    tid = 8; s = cyc + 1;
    bus.force_ready_mode_i = 1'b1;
    ex(s + 2, S_BUSY, 1); ex(s + 2, S_CNT, 2); ex(s + 2, S_FR, 3);
    ex(s + 3, S_EN, 0); ex(s + 3, S_BUSY, 0); ex(s + 3, S_CNT, 0); ex(s + 3, S_FU, 0);
    ex(s + 3, S_FR, 0); ex(s + 3, S_R0, 0); ex(s + 3, S_DONE, 0);
    ex(s + 4, S_DONE, 0); ex(s + 4, S_TO, 0); ex(s + 4, S_BUSY, 0);
    start_run(2'b11);
    wait_cyc(s + 3); rst_ni = 1'b0;
    step(1); rst_ni = 1'b1; bus.force_ready_mode_i = 1'b0;
    step(1);

    // RNG range and reset reproducibility over 10000 RUN cycles per pass.
    tid = 9;
    rng_pass(0);
    rst_ni = 1'b0; step(2); rst_ni = 1'b1; step(1);
    rng_pass(1);
    step(3);

    vectors++;
    if (rec0.size() != 10000) begin
      errors++;
      $display("FAIL rng_count: recorded %0d RUN cycles, required 10000", rec0.size());
    end
    vectors++;
    if (rec1.size() != rec0.size()) begin
      errors++;
      $display("FAIL rng_replay_len: second pass %0d samples, required %0d", rec1.size(), rec0.size());
    end
    nd = 0;
    for (int i = 0; i < rec0.size() && i < rec1.size(); i++)
      if (rec0[i] !== rec1[i]) nd++;
    vectors++;
    if (nd != 0) begin
      errors++;
      $display("FAIL rng_replay: %0d differing samples, required 0", nd);
    end
    vectors++;
    if (range_bad != 0) begin
      errors++;
      $display("FAIL rng_range: %0d samples above 999, required 0", range_bad);
    end
    vectors++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations unchecked, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/hwpe_stream_traffic_ctrl.md
Name: hwpe_stream_traffic_ctrl

Overview:
Testbench-side scheduler that sequences NB_RECV stream traffic receivers through a run. It drives each receiver's enable, force-ready, force-unready and per-receiver random-number inputs, and injects periodic global stall bursts. It aggregates the receivers' end-of-transfer flags into done/timeout status. It sits in the verification top between the test program and the receiver instances.

Parameters:
NB_RECV, 2, number of controlled receivers (1..16)
SEED, 32'h1, LFSR seed base; receiver i is seeded SEED+i (value 0 forced to 1)
STALL_PERIOD, 64, cycles between stall-burst starts during RUN; 0 disables bursts
STALL_LEN, 4, length of each stall burst in cycles; must be < STALL_PERIOD
TIMEOUT_CYCLES, 100000, RUN cycles before declaring timeout; 0 disables timeout

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  pulse: begin run (accepted only in IDLE)
clear_i  in  1  pulse: return from DONE/TIMEOUT to IDLE
mask_i  in  NB_RECV  receivers participating in run; sampled on accepted start
force_ready_mode_i  in  1  when 1, force_ready_o asserted for all active receivers throughout RUN
eot_i  in  NB_RECV  per-receiver end-of-transfer
enable_o  out  NB_RECV  per-receiver enable
force_ready_o  out  NB_RECV  per-receiver force ready
force_unready_o  out  NB_RECV  per-receiver force unready (stall burst)
rng_o  out  NB_RECV x 32  per-receiver random value, range 0..999
busy_o  out  1  state==RUN
done_o  out  1  state==DONE
timeout_o  out  1  state==TIMEOUT
cycle_cnt_o  out  32  RUN cycles elapsed in current/last run

Behaviour:
- Reset: state=IDLE; all outputs 0; mask register 0; cycle counter 0; stall counter 0; LFSRs reloaded with seeds. A reset mid-RUN aborts immediately, with no done/timeout pulse.
- States: IDLE, RUN, DONE, TIMEOUT. All outputs are registered.
- IDLE, start_i=1: latch mask_i, clear cycle_cnt and stall counter, go to RUN. enable_o=mask is visible the cycle after the start edge, i.e. 1-cycle latency. start_i is ignored in every other state.
- RUN:
  - enable_o = mask.
  - force_ready_o = mask when force_ready_mode_i=1, else 0. force_ready_mode_i is sampled every cycle.
  - cycle_cnt increments every RUN cycle and saturates at 2^32-1.
- Stall bursts (RUN only, STALL_PERIOD>0): the stall counter counts 0..STALL_PERIOD-1 and wraps. force_unready_o = mask while counter < STALL_LEN, else 0. The first burst starts on the first RUN cycle.
- Completion: effective_eot = eot_i | ~mask. When all bits of effective_eot are 1, go to DONE.
  - If mask=0 at start, DONE is reached after one RUN cycle.
- Timeout: when TIMEOUT_CYCLES>0 and cycle_cnt reaches TIMEOUT_CYCLES-1 without completion, go to TIMEOUT.
  - If completion and timeout occur in the same cycle, DONE wins.
- DONE/TIMEOUT: enable_o, force_ready_o and force_unready_o are 0; the status flag is held and cycle_cnt is frozen. clear_i goes to IDLE and zeroes cycle_cnt. start_i here is ignored, even if simultaneous with clear_i.
- RNG: one 32-bit Galois LFSR per receiver, polynomial x^32+x^22+x^2+x+1.
  - Each LFSR advances every cycle in RUN only; it holds in other states and is not reseeded between runs.
  - Let v = lfsr[9:0]. rng_o[i] = v-1000 when v>=1000, else v, zero-extended to 32 bits. rng_o is always in 0..999.
- eot_i may be asynchronous to protocol events but is sampled only on clk_i. No eot_i latching occurs outside RUN.

Test Plan:
1. Reset, then start with mask=2'b11, eot_i held 0, STALL_PERIOD=8, STALL_LEN=2 -> enable_o=2'b11 one cycle after start; force_unready_o=2'b11 on RUN cycles 0,1,8,9,16,17; 0 otherwise.
2. Same run, raise eot_i[0] at cycle 10 and eot_i[1] at cycle 20 -> done_o=1 the cycle after cycle 20; enable_o=0; cycle_cnt_o=21 held until clear_i, then 0 and state IDLE.
3. mask=2'b01, eot_i[1]=0 forever, eot_i[0] rises at cycle 5 -> DONE (unmasked receiver ignored); enable_o[1]=0 throughout.
4. TIMEOUT_CYCLES=50, eot_i=0 -> timeout_o=1 after 50 RUN cycles, cycle_cnt_o=50. In a second run, eot_i rises exactly on cycle 49 -> done_o, not timeout_o.
5. force_ready_mode_i toggled mid-RUN with mask=2'b10 -> force_ready_o follows it as 2'b10/2'b00 with 1-cycle latency. start_i pulsed in RUN -> no effect.
6. Assert rst_ni low mid-RUN -> all outputs 0 asynchronously. Check rng_o stays in 0..999 over 10000 cycles with SEED=1, and the sequence is reproducible across two resets.
